bus_slave_regs: RTL and testbench
=================================

BUS_SLAVE_REGS -- requirements
Module: bus_slave_regs

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait states inserted before rdy_ (legal range 0..15).
REQ-002 Parameter ID_VALUE, default 32'h415A_5052, constant returned by register 7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cs_  input  1  chip select from the address decoder, active-low.
REQ-006 as_  input  1  address strobe from the selected master, active-low.
REQ-007 rw  input  1  transfer direction, READ or WRITE per the bus encoding.
REQ-008 addr  input  30  word address; only bits [2:0] decoded.
REQ-009 wr_data  input  32  write data.
REQ-010 rd_data  output  32  read data, valid only while rdy_ is low.
REQ-011 rdy_  output  1  transfer-complete strobe, active-low, registered.
REQ-012 reg0_out  output  32  live copy of register 0 for local control use.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 Eight 32-bit registers: indices 0..6 read/write; index 7 read-only, returns ID_VALUE, and ignores writes.
REQ-015 FSM states are IDLE, WAIT, RESP and TURN.
REQ-016 IDLE: when cs_ and as_ are both low at a rising edge, latch addr[2:0], rw and wr_data, and load the wait counter with WAIT_CYCLES.
REQ-017 IDLE exit: go to RESP if WAIT_CYCLES is 0, otherwise go to WAIT.
REQ-018 WAIT: decrement the counter each cycle, and go to RESP on the edge where the counter equals 1.
REQ-019 WAIT abort: if as_ or cs_ is high at an edge in WAIT, return to IDLE with no register write and no rdy_ assertion.
REQ-020 On the edge entering RESP, a latched write is committed to the addressed register.
REQ-021 On the edge entering RESP, a latched read loads rd_data from the addressed register.
REQ-022 RESP lasts exactly one cycle, with rdy_ low in that cycle, then the FSM goes to TURN.
REQ-023 TURN lasts one cycle, ignores cs_ and as_, then the FSM goes to IDLE, so a strobe held one cycle past rdy_ is never double-accepted.
REQ-024 Latency: rdy_ is low in the cycle beginning WAIT_CYCLES+1 edges after the sampling edge, which is 1 cycle when WAIT_CYCLES is 0.
REQ-025 rd_data is 0 in every cycle outside RESP, and also 0 in RESP for writes.
REQ-026 Changes on addr, rw or wr_data after the sampling edge have no effect on the current transfer.
REQ-027 Back-to-back transfers: the minimum spacing between sampling edges is WAIT_CYCLES+3 cycles.
REQ-028 A read that follows a write to the same index returns the newly written value.
REQ-029 reg0_out reflects a write to register 0 from the cycle after the commit edge.

Reset
REQ-030 When reset is low, the FSM goes immediately to IDLE and the wait counter clears.
REQ-031 When reset is low, registers 0..6 clear to 0, rdy_ goes high, rd_data goes to 0, reg0_out goes to 0, and busy goes low, all asynchronously.
REQ-032 A transfer in progress at reset is discarded: no write is committed and no rdy_ is asserted after reset release.
REQ-033 The first request is accepted on the first rising edge after reset deassertion.

Structure
REQ-034 State encodings, register index constants, and the ID_VALUE default are defined in a shared header, bus_slave_regs.h, included alongside bus.h.
REQ-035 The wait-state counter is a sub-module, bus_wait_counter, with load, decrement and a terminal-count output.
REQ-036 The register array and the FSM reside in bus_slave_regs.

Verification
REQ-037 WAIT_CYCLES=2: write 32'hDEAD_BEEF to index 3, then read index 3 -> rdy_ is low 3 cycles after each sampling edge, the read returns DEAD_BEEF, and busy is high for 4 cycles per transfer.
REQ-038 WAIT_CYCLES=0: read index 7 -> rdy_ is low 1 cycle after sampling with rd_data=32'h415A_5052; a write of 32'h1 to index 7 followed by a read still returns 415A_5052.
REQ-039 WAIT_CYCLES=2: as_ deasserted 1 cycle into a write to index 1 -> no rdy_, and a later read of index 1 returns 0.
REQ-040 Write of 32'h0000_00A5 to index 0 -> reg0_out equals 00A5 from the cycle after rdy_ and holds it until the next write.
REQ-041 Master holds as_ low for 1 cycle past rdy_ -> exactly one transfer and one rdy_ pulse occur.
REQ-042 Reset asserted during WAIT of a write of 32'hFFFF_FFFF to index 2 -> no rdy_ ever asserted, and a read of index 2 after reset release returns 0.

Source files
------------

// File: rtl/bus_slave_regs_pkg.sv
// Shared definitions for the bus slave register block: FSM encoding, bus
// direction encoding, register indices and the default identification word.
package bus_slave_regs_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_TURN = 2'd3
    } fsm_state_t;

    // Bus direction encoding on rw.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int          NUM_RW_REGS      = 7;
    localparam logic [2:0]  IDX_CTRL         = 3'd0;
    localparam logic [2:0]  IDX_ID           = 3'd7;
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h415A_5052;

    // Wait counter width covers the legal WAIT_CYCLES range 0..15.
    localparam int CNT_W = 4;

    function automatic logic is_writable(input logic [2:0] idx);
        return idx != IDX_ID;
    endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Wait-state down-counter: loadable, decrements on request, and flags the
// last wait cycle (count == 1) so the FSM can move to the response phase.
module bus_wait_counter
    import bus_slave_regs_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    input  logic             i_clear,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    // Load wins over clear so a fresh transfer is never lost to an abort.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == CNT_W'(1));

endmodule

// File: rtl/bus_slave_regs.sv
// Eight-word bus slave register file with programmable wait states: seven
// read/write registers plus a read-only identification word at index 7.
module bus_slave_regs
    import bus_slave_regs_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic [31:0] reg0_out,
    output logic        busy,
    output fsm_state_t  o_dbg_state
);

    // Handshake: a request is accepted in IDLE on an edge where cs_ and as_
    // are both low; the master must hold them low through WAIT (releasing
    // either aborts) and completes when it sees rdy_ low for one cycle.
    // TURN ignores the strobes so a late release is not re-accepted.

    localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WAIT_CYCLES);

    fsm_state_t  r_state;
    fsm_state_t  w_state_next;
    logic [2:0]  r_idx;
    logic        r_rw;
    logic [31:0] r_wdata;
    logic [31:0] r_regs [NUM_RW_REGS];

    logic        w_accept;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_cnt_clear;
    logic        w_cnt_tc;
    logic        w_enter_resp;
    logic        w_wr_en;
    logic [2:0]  w_x_idx;
    logic        w_x_rw;
    logic [31:0] w_x_data;
    logic [31:0] w_rd_sel;
    logic [26:0] w_unused_addr;

    assign w_unused_addr = addr[29:3];
    assign w_accept      = (r_state == S_IDLE) && !cs_ && !as_;

    bus_wait_counter u_wait_counter (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_load     (w_cnt_load),
        .i_load_val (W_LOAD),
        .i_dec      (w_cnt_dec),
        .i_clear    (w_cnt_clear),
        .o_tc       (w_cnt_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_cnt_clear  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_load   = 1'b1;
                    w_state_next = (W_LOAD == '0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cs_ || as_) begin
                    w_cnt_clear  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                    if (w_cnt_tc) begin
                        w_state_next = S_RESP;
                    end
                end
            end
            S_RESP:  w_state_next = S_TURN;
            S_TURN:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the sampling edge itself, so
    // the live bus fields are used there instead of the latched copies.
    assign w_x_idx  = (r_state == S_IDLE) ? addr[2:0] : r_idx;
    assign w_x_rw   = (r_state == S_IDLE) ? rw        : r_rw;
    assign w_x_data = (r_state == S_IDLE) ? wr_data   : r_wdata;

    assign w_enter_resp = (w_state_next == S_RESP);
    assign w_wr_en      = w_enter_resp && (w_x_rw == RW_WRITE) && is_writable(w_x_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx   <= '0;
            r_rw    <= RW_READ;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_idx   <= addr[2:0];
            r_rw    <= rw;
            r_wdata <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (w_wr_en && (w_x_idx == 3'(i))) begin
                    r_regs[i] <= w_x_data;
                end
            end
        end
    end

    always_comb begin
        w_rd_sel = ID_VALUE;
        for (int i = 0; i < NUM_RW_REGS; i++) begin
            if (w_x_idx == 3'(i)) begin
                w_rd_sel = r_regs[i];
            end
        end
    end

    // rdy_ and rd_data are registered so they line up exactly with RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_    <= 1'b1;
            rd_data <= '0;
        end else begin
            rdy_    <= !w_enter_resp;
            rd_data <= (w_enter_resp && (w_x_rw == RW_READ)) ? w_rd_sel : '0;
        end
    end

    assign reg0_out    = r_regs[IDX_CTRL];
    assign busy        = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_slave_regs.sv
// Bench for bus_slave_regs: one instance with two wait states, one with none,
// driven by a table of transfers plus reset and strobe-timing sequences.
module tb_bus_slave_regs;
    import bus_slave_regs_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n   [2];
    logic        as_n   [2];
    logic        rw_v   [2];
    logic [29:0] addr_v [2];
    logic [31:0] wd_v   [2];
    logic [31:0] rd_v   [2];
    logic [31:0] reg0_v [2];
    logic        rdy_v  [2];
    logic        busy_v [2];
    fsm_state_t  st_v   [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    bus_slave_regs #(.WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .cs_(cs_n[0]), .as_(as_n[0]), .rw(rw_v[0]),
        .addr(addr_v[0]), .wr_data(wd_v[0]), .rd_data(rd_v[0]), .rdy_(rdy_v[0]),
        .reg0_out(reg0_v[0]), .busy(busy_v[0]), .o_dbg_state(st_v[0])
    );

    bus_slave_regs #(.WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset), .cs_(cs_n[1]), .as_(as_n[1]), .rw(rw_v[1]),
        .addr(addr_v[1]), .wr_data(wd_v[1]), .rd_data(rd_v[1]), .rdy_(rdy_v[1]),
        .reg0_out(reg0_v[1]), .busy(busy_v[1]), .o_dbg_state(st_v[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transfer on instance d, observed for 8 cycles after the sampling edge.
    task automatic xfer(input int d, input logic rw_i, input logic [2:0] idx,
                        input logic [31:0] wd, input int abort_at, input int hold,
                        output int n_rdy, output int rdy_cyc, output logic [31:0] rdata,
                        output int n_busy, output int n_rd_nz, output logic [31:0] reg0_next);
        int rel;
        rel = 0; n_rdy = 0; rdy_cyc = 0; rdata = '0; n_busy = 0; n_rd_nz = 0; reg0_next = '0;
        @(negedge clk);
        addr_v[d] = {27'($urandom), idx};
        wd_v[d]   = wd;
        rw_v[d]   = rw_i;
        cs_n[d]   = 1'b0;
        as_n[d]   = 1'b0;
        @(posedge clk);
        #1;
        addr_v[d] = ~addr_v[d];
        wd_v[d]   = ~wd;
        rw_v[d]   = ~rw_i;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (!rdy_v[d]) begin
                n_rdy++;
                if (rdy_cyc == 0) begin
                    rdy_cyc = cyc;
                    rdata   = rd_v[d];
                end
            end else if (rd_v[d] != '0) begin
                n_rd_nz++;
            end
            if (busy_v[d]) n_busy++;
            if (rdy_cyc != 0 && cyc == rdy_cyc + 1) reg0_next = reg0_v[d];
            @(negedge clk);
            if (rel == 0 && (cyc == abort_at || (rdy_cyc != 0 && cyc >= rdy_cyc + hold) || cyc == 8)) begin
                cs_n[d] = 1'b1;
                as_n[d] = 1'b1;
                rel     = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        int          d;
        logic        rw;
        logic [2:0]  idx;
        logic [31:0] wd;
        int          abort_at;
        int          hold;
        int          exp_rdy;
        logic [31:0] exp_rd;
        int          exp_busy;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int          n_rdy, rdy_cyc, n_busy, n_rd_nz, lat, bad_rdy;
        logic [31:0] rdata, reg0_next, exp_rd;

        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cs_n[d] = 1'b1; as_n[d] = 1'b1; rw_v[d] = RW_READ; addr_v[d] = '0; wd_v[d] = '0;
        end

        // d=0: WAIT_CYCLES=2, d=1: WAIT_CYCLES=0
        vecs[0]  = '{0, RW_WRITE, 3'd3, 32'hDEAD_BEEF, 0, 0, 1, 32'h0,         4};
        vecs[1]  = '{0, RW_READ,  3'd3, 32'h0,         0, 0, 1, 32'hDEAD_BEEF, 4};
        vecs[2]  = '{1, RW_READ,  3'd7, 32'h0,         0, 0, 1, 32'h415A_5052, 2};
        vecs[3]  = '{1, RW_WRITE, 3'd7, 32'h0000_0001, 0, 0, 1, 32'h0,         2};
        vecs[4]  = '{1, RW_READ,  3'd7, 32'h0,         0, 0, 1, 32'h415A_5052, 2};
        vecs[5]  = '{0, RW_WRITE, 3'd1, 32'h1234_5678, 1, 0, 0, 32'h0,         1};
        vecs[6]  = '{0, RW_READ,  3'd1, 32'h0,         0, 0, 1, 32'h0,         4};
        vecs[7]  = '{0, RW_WRITE, 3'd0, 32'h0000_00A5, 0, 0, 1, 32'h0,         4};
        vecs[8]  = '{0, RW_READ,  3'd0, 32'h0,         0, 0, 1, 32'h0000_00A5, 4};
        vecs[9]  = '{0, RW_WRITE, 3'd4, 32'hCAFE_F00D, 0, 1, 1, 32'h0,         4};
        vecs[10] = '{0, RW_READ,  3'd4, 32'h0,         0, 1, 1, 32'hCAFE_F00D, 4};
        vecs[11] = '{1, RW_WRITE, 3'd5, 32'h5555_AAAA, 0, 1, 1, 32'h0,         2};
        vecs[12] = '{1, RW_READ,  3'd5, 32'h0,         0, 0, 1, 32'h5555_AAAA, 2};
        vecs[13] = '{1, RW_READ,  3'd6, 32'h0,         0, 0, 1, 32'h0,         2};
        vecs[14] = '{0, RW_READ,  3'd7, 32'h0,         0, 0, 1, 32'h415A_5052, 4};
        vecs[15] = '{1, RW_READ,  3'd3, 32'h0,         0, 0, 1, 32'h0,         2};

        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst%0d_rdy", d),   32'(rdy_v[d]),  32'd1);
            check($sformatf("rst%0d_busy", d),  32'(busy_v[d]), 32'd0);
            check($sformatf("rst%0d_rd", d),    rd_v[d],        32'h0);
            check($sformatf("rst%0d_reg0", d),  reg0_v[d],      32'h0);
            check($sformatf("rst%0d_state", d), 32'(st_v[d]),   32'(S_IDLE));
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(vecs[i].exp_rd);
            xfer(vecs[i].d, vecs[i].rw, vecs[i].idx, vecs[i].wd, vecs[i].abort_at, vecs[i].hold,
                 n_rdy, rdy_cyc, rdata, n_busy, n_rd_nz, reg0_next);
            lat    = (vecs[i].d == 0) ? 3 : 1;
            exp_rd = exp_q.pop_front();
            check($sformatf("v%0d_rdy_count", i), 32'(n_rdy), 32'(vecs[i].exp_rdy));
            if (vecs[i].exp_rdy != 0) check($sformatf("v%0d_latency", i), 32'(rdy_cyc), 32'(lat));
            check($sformatf("v%0d_rd_data", i), rdata, exp_rd);
            check($sformatf("v%0d_busy_cycles", i), 32'(n_busy), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d_rd_idle_zero", i), 32'(n_rd_nz), 32'd0);
            check($sformatf("v%0d_end_state", i), 32'(st_v[vecs[i].d]), 32'(S_IDLE));
            if (i == 7) check("reg0_after_rdy", reg0_next, 32'h0000_00A5);
            if (i == 9) check("reg0_holds", reg0_v[0], 32'h0000_00A5);
        end
        check("reg0_other_inst", reg0_v[1], 32'h0);

        // Reset in the middle of a WAIT phase discards the write.
        @(negedge clk);
        addr_v[0] = 30'd2; wd_v[0] = 32'hFFFF_FFFF; rw_v[0] = RW_WRITE;
        cs_n[0] = 1'b0; as_n[0] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_wait_state", 32'(st_v[0]), 32'(S_WAIT));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_rst_rdy",   32'(rdy_v[0]),  32'd1);
        check("async_rst_busy",  32'(busy_v[0]), 32'd0);
        check("async_rst_rd",    rd_v[0],        32'h0);
        check("async_rst_reg0",  reg0_v[0],      32'h0);
        check("async_rst_state", 32'(st_v[0]),   32'(S_IDLE));
        cs_n[0] = 1'b1; as_n[0] = 1'b1;
        bad_rdy = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (!rdy_v[0]) bad_rdy++;
        end
        reset = 1'b1;
        xfer(0, RW_READ, 3'd2, 32'h0, 0, 0, n_rdy, rdy_cyc, rdata, n_busy, n_rd_nz, reg0_next);
        check("post_rst_no_rdy", 32'(bad_rdy), 32'd0);
        check("post_rst_rdy_count", 32'(n_rdy), 32'd1);
        check("post_rst_latency", 32'(rdy_cyc), 32'd3);
        check("post_rst_read2", rdata, 32'h0);
        check("post_rst_read3_busy", 32'(n_busy), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
